marker_tracker: RTL and testbench
=================================

# marker_tracker

Frame-to-frame tracker that sits directly downstream of the per-frame marker detector. On each vsync it snapshots the detector's candidate array (centre x, y, diameter, valid), greedily matches candidates to persistent track slots by L1 distance, ages out lost tracks and allocates new ones. It publishes a stable, consistently indexed set of marker tracks once per frame for the overlay and pose logic.

## Interface
- NUM_TARGETS, 4, number of candidates and number of track slots
- SCREEN_WIDTH, 1280, defines X_W = $clog2(SCREEN_WIDTH)
- SCREEN_HEIGHT, 720, defines Y_W = $clog2(SCREEN_HEIGHT)+1
- MAX_JUMP, 32, maximum L1 distance (pixels) for a candidate to continue a track
- MAX_MISSES, 3, consecutive unmatched frames before a track is dropped
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- vsync_in  input  1  frame strobe; rising edge starts processing
- cand_x_in  input  [NUM_TARGETS-1:0][X_W-1:0]  candidate centre x
- cand_y_in  input  [NUM_TARGETS-1:0][Y_W-1:0]  candidate row
- cand_d_in  input  [NUM_TARGETS-1:0][Y_W-1:0]  candidate diameter
- cand_valid_in  input  NUM_TARGETS  candidate valid
- track_x_out  output  [NUM_TARGETS-1:0][X_W-1:0]  tracked x
- track_y_out  output  [NUM_TARGETS-1:0][Y_W-1:0]  tracked y
- track_d_out  output  [NUM_TARGETS-1:0][Y_W-1:0]  tracked diameter
- track_valid_out  output  NUM_TARGETS  slot holds a live track
- frame_valid_out  output  1  one-cycle pulse: outputs just updated
- busy_out  output  1  high whenever state is not IDLE

## Operation
- vsync_in registered once; rising edge detected as vsync_q & ~vsync_qq.
- States: IDLE, MATCH, ASSIGN, DONE.
- IDLE: on edge, snapshot all cand_* into internal registers, clear used mask, i=j=0, go MATCH.
- MATCH: one (slot i, candidate j) pair per cycle, j inner. Pair considered if slot i live, candidate j valid and not used. dist = |dx|+|dy|, width max(X_W,Y_W)+1. Running minimum uses strict <, so ties go to lowest j. At j==N-1, commit slot i:
  - best found and best_dist <= MAX_JUMP: update slot from candidate, miss=0, set used[best].
  - live, no match: miss+1; if miss+1 == MAX_MISSES, clear live and miss.
  - not live: unchanged. Dead slots still take N cycles (fixed latency).
  - After i==N-1 commit go ASSIGN, k=0.
- ASSIGN: one candidate k per cycle; if valid and not used, write into lowest-index non-live slot (priority encoder), live=1, miss=0. If no free slot, candidate is discarded. A slot filled here is immediately non-free for later k. After k==N-1 go DONE.
- DONE: copy internal slots to track_*_out, pulse frame_valid_out, go IDLE.
- vsync edge while not IDLE is dropped; no queued frame.

## Timing
- Reset (async): all outputs 0, internal slots/miss/used 0, state IDLE.
- Latency from registered edge detect to frame_valid_out: 1 (snapshot) + N*N (MATCH) + N (ASSIGN) + 1 (DONE) = 22 cycles for N=4.
- Outputs change only in the DONE cycle and hold until the next DONE.
- Inputs are sampled only in the snapshot cycle; later changes are ignored.
- Reset mid-operation aborts immediately; no frame_valid_out.

## Configuration
- TRACKER_SMOOTH_EN defined: a matched slot updates as (old + new + 1) >> 1 for x, y and d, with a one-bit-wider intermediate. Newly allocated slots take the raw value.
- TRACKER_SMOOTH_EN undefined: a matched slot takes the candidate value directly.

## Structure
- Shared package marker_pkg: tracker_state_t enum, and an l1_dist function parameterised on width.
- One sub-module, tracker_free_slot: combinational lowest-index-zero priority encoder over live bits, with found flag.

## Test plan
- Reset: assert rst_in mid-clock -> all outputs 0, busy_out 0 immediately.
- First frame: cand0=(100,50,20), cand1=(300,60,18), others invalid -> 22 cycles later a one-cycle frame_valid_out; slot0=(100,50,20), slot1=(300,60,18), track_valid_out=0011.
- Swapped order: next frame cand0=(305,62,18), cand1=(102,49,20) -> without the macro, slot0=(102,49), slot1=(305,62). With TRACKER_SMOOTH_EN, slot0=(101,50), slot1=(303,61). track_valid_out stays 0011.
- Jump: slot0 at (100,50), single candidate (200,50) -> slot0 miss=1 and unchanged; candidate allocated to slot2; track_valid_out=0111 (slot1 also missed).
- Loss: three consecutive frames with no candidates -> track_valid_out drops to 0000 on the third frame_valid_out, not earlier.
- Overrun: second vsync edge 10 cycles after the first -> exactly one frame_valid_out, at cycle 22 of the first frame.

Source files
------------

// File: rtl/marker_pkg.sv
// rtl/marker_pkg.sv - shared types and distance helper for the marker tracker
package marker_pkg;

  typedef enum logic [1:0] {IDLE, MATCH, ASSIGN, DONE} tracker_state_t;

  // Operands arrive zero-extended to 32 bits; callers keep the low bits they need.
  function automatic logic [31:0] l1_dist(input logic [31:0] ax, input logic [31:0] bx,
                                          input logic [31:0] ay, input logic [31:0] by);
    logic [31:0] dx;
    logic [31:0] dy;
    dx = (ax > bx) ? (ax - bx) : (bx - ax);
    dy = (ay > by) ? (ay - by) : (by - ay);
    return dx + dy;
  endfunction

endpackage

// File: rtl/tracker_free_slot.sv
// rtl/tracker_free_slot.sv - lowest-index free (non-live) slot priority encoder
module tracker_free_slot #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     live,
  output logic [IDX_W-1:0] free_idx,
  output logic             found
);

  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int n = N - 1; n >= 0; n--) begin
      if (!live[n]) begin
        free_idx = IDX_W'(n);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/marker_tracker.sv
// rtl/marker_tracker.sv - per-frame greedy L1 matcher of detector candidates to persistent track slots
// Optional macro TRACKER_SMOOTH_EN: matched slots average old and new position/diameter.
module marker_tracker
  import marker_pkg::*;
#(
  parameter int NUM_TARGETS   = 4,
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int MAX_JUMP      = 32,
  parameter int MAX_MISSES    = 3,
  parameter int X_W           = $clog2(SCREEN_WIDTH),
  parameter int Y_W           = $clog2(SCREEN_HEIGHT) + 1
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             vsync_in,
  input  logic [NUM_TARGETS-1:0][X_W-1:0]  cand_x_in,
  input  logic [NUM_TARGETS-1:0][Y_W-1:0]  cand_y_in,
  input  logic [NUM_TARGETS-1:0][Y_W-1:0]  cand_d_in,
  input  logic [NUM_TARGETS-1:0]           cand_valid_in,
  output logic [NUM_TARGETS-1:0][X_W-1:0]  track_x_out,
  output logic [NUM_TARGETS-1:0][Y_W-1:0]  track_y_out,
  output logic [NUM_TARGETS-1:0][Y_W-1:0]  track_d_out,
  output logic [NUM_TARGETS-1:0]           track_valid_out,
  output logic                             frame_valid_out,
  output logic                             busy_out
);

  localparam int IDX_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int MISS_W = $clog2(MAX_MISSES + 1);
  localparam int D_W    = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TARGETS - 1);

  tracker_state_t state;
  logic vsync_q, vsync_qq;
  logic [NUM_TARGETS-1:0][X_W-1:0]    snap_x, slot_x;
  logic [NUM_TARGETS-1:0][Y_W-1:0]    snap_y, snap_d, slot_y, slot_d;
  logic [NUM_TARGETS-1:0]             snap_valid, slot_live, used;
  logic [NUM_TARGETS-1:0][MISS_W-1:0] slot_miss;
  logic [IDX_W-1:0] i_idx, j_idx, k_idx, best_idx;
  logic [D_W-1:0]   best_dist;
  logic             best_found;

  logic             vsync_rise;
  logic [D_W-1:0]   pair_dist, fin_dist;
  logic             pair_better, fin_found;
  logic [IDX_W-1:0] fin_idx, free_idx;
  logic             free_found;
  logic [X_W-1:0]   upd_x;
  logic [Y_W-1:0]   upd_y, upd_d;

  assign vsync_rise = vsync_q & ~vsync_qq;
  assign busy_out   = (state != IDLE);

  tracker_free_slot #(.N(NUM_TARGETS), .IDX_W(IDX_W)) u_free_slot (
    .live     (slot_live),
    .free_idx (free_idx),
    .found    (free_found)
  );

  // Running minimum including the pair under test, so the last j can commit in the same cycle.
  always_comb begin
    pair_dist   = D_W'(l1_dist(32'(slot_x[i_idx]), 32'(snap_x[j_idx]),
                               32'(slot_y[i_idx]), 32'(snap_y[j_idx])));
    pair_better = slot_live[i_idx] && snap_valid[j_idx] && !used[j_idx] &&
                  (!best_found || (pair_dist < best_dist));
    fin_found   = best_found | pair_better;
    fin_idx     = pair_better ? j_idx : best_idx;
    fin_dist    = pair_better ? pair_dist : best_dist;
`ifdef TRACKER_SMOOTH_EN
    upd_x = X_W'(({1'b0, slot_x[i_idx]} + {1'b0, snap_x[fin_idx]} + (X_W+1)'(1)) >> 1);
    upd_y = Y_W'(({1'b0, slot_y[i_idx]} + {1'b0, snap_y[fin_idx]} + (Y_W+1)'(1)) >> 1);
    upd_d = Y_W'(({1'b0, slot_d[i_idx]} + {1'b0, snap_d[fin_idx]} + (Y_W+1)'(1)) >> 1);
`else
    upd_x = snap_x[fin_idx];
    upd_y = snap_y[fin_idx];
    upd_d = snap_d[fin_idx];
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      vsync_q <= 1'b0;
      vsync_qq <= 1'b0;
      snap_x <= '0; snap_y <= '0; snap_d <= '0; snap_valid <= '0;
      slot_x <= '0; slot_y <= '0; slot_d <= '0; slot_live <= '0;
      slot_miss <= '0;
      used <= '0;
      i_idx <= '0; j_idx <= '0; k_idx <= '0; best_idx <= '0;
      best_dist <= '0;
      best_found <= 1'b0;
      track_x_out <= '0; track_y_out <= '0; track_d_out <= '0; track_valid_out <= '0;
      frame_valid_out <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      vsync_qq <= vsync_q;
      frame_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (vsync_rise) begin
            snap_x <= cand_x_in;
            snap_y <= cand_y_in;
            snap_d <= cand_d_in;
            snap_valid <= cand_valid_in;
            used <= '0;
            i_idx <= '0;
            j_idx <= '0;
            best_found <= 1'b0;
            state <= MATCH;
          end
        end
        MATCH: begin
          if (j_idx == LAST) begin
            if (fin_found && (fin_dist <= D_W'(MAX_JUMP))) begin
              slot_x[i_idx] <= upd_x;
              slot_y[i_idx] <= upd_y;
              slot_d[i_idx] <= upd_d;
              slot_miss[i_idx] <= '0;
              used[fin_idx] <= 1'b1;
            end else if (slot_live[i_idx]) begin
              if (slot_miss[i_idx] + MISS_W'(1) == MISS_W'(MAX_MISSES)) begin
                slot_live[i_idx] <= 1'b0;
                slot_miss[i_idx] <= '0;
              end else begin
                slot_miss[i_idx] <= slot_miss[i_idx] + MISS_W'(1);
              end
            end
            best_found <= 1'b0;
            j_idx <= '0;
            if (i_idx == LAST) begin
              k_idx <= '0;
              state <= ASSIGN;
            end else begin
              i_idx <= i_idx + IDX_W'(1);
            end
          end else begin
            best_found <= fin_found;
            best_idx <= fin_idx;
            best_dist <= fin_dist;
            j_idx <= j_idx + IDX_W'(1);
          end
        end
        ASSIGN: begin
          if (snap_valid[k_idx] && !used[k_idx] && free_found) begin
            slot_x[free_idx] <= snap_x[k_idx];
            slot_y[free_idx] <= snap_y[k_idx];
            slot_d[free_idx] <= snap_d[k_idx];
            slot_live[free_idx] <= 1'b1;
            slot_miss[free_idx] <= '0;
          end
          if (k_idx == LAST) state <= DONE;
          else k_idx <= k_idx + IDX_W'(1);
        end
        DONE: begin
          track_x_out <= slot_x;
          track_y_out <= slot_y;
          track_d_out <= slot_d;
          track_valid_out <= slot_live;
          frame_valid_out <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_marker_tracker.sv
// tb/tb_marker_tracker.sv - scoreboard bench for marker_tracker
module tb_marker_tracker;

  logic clk_in = 1'b0;
  logic rst_in;
  logic vsync_in;
  logic [3:0][10:0] cand_x_in, cand_y_in, cand_d_in;
  logic [3:0]       cand_valid_in;
  logic [3:0][10:0] track_x_out, track_y_out, track_d_out;
  logic [3:0]       track_valid_out;
  logic             frame_valid_out, busy_out;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][10:0] x;
    logic [3:0][10:0] y;
    logic [3:0][10:0] d;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   frame_no = 0;
  logic prev_fv = 1'b0;

  marker_tracker dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .vsync_in        (vsync_in),
    .cand_x_in       (cand_x_in),
    .cand_y_in       (cand_y_in),
    .cand_d_in       (cand_d_in),
    .cand_valid_in   (cand_valid_in),
    .track_x_out     (track_x_out),
    .track_y_out     (track_y_out),
    .track_d_out     (track_d_out),
    .track_valid_out (track_valid_out),
    .frame_valid_out (frame_valid_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.valid = '0; e.x = '0; e.y = '0; e.d = '0; e.cyc = 0;
    return e;
  endfunction

  // Monitor: every frame_valid_out pulse must match the oldest expected frame.
  always @(negedge clk_in) begin
    if (frame_valid_out) begin
      chk("pulse_width", {63'd0, prev_fv}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        frame_no++;
        chk($sformatf("f%0d_latency", frame_no), 64'(cyc), 64'(e.cyc));
        chk($sformatf("f%0d_valid", frame_no), 64'(track_valid_out), 64'(e.valid));
        for (int s = 0; s < 4; s++) begin
          if (e.valid[s]) begin
            chk($sformatf("f%0d_slot%0d_x", frame_no, s), 64'(track_x_out[s]), 64'(e.x[s]));
            chk($sformatf("f%0d_slot%0d_y", frame_no, s), 64'(track_y_out[s]), 64'(e.y[s]));
            chk($sformatf("f%0d_slot%0d_d", frame_no, s), 64'(track_d_out[s]), 64'(e.d[s]));
          end
        end
      end
    end
    prev_fv = frame_valid_out;
  end

  task automatic clear_cands();
    cand_x_in = '0; cand_y_in = '0; cand_d_in = '0; cand_valid_in = '0;
  endtask

  task automatic set_cand(input int n, input int x, input int y, input int d);
    cand_x_in[n] = 11'(x);
    cand_y_in[n] = 11'(y);
    cand_d_in[n] = 11'(d);
    cand_valid_in[n] = 1'b1;
  endtask

  task automatic set_slot(inout exp_t e, input int s, input int x, input int y, input int d);
    e.x[s] = 11'(x); e.y[s] = 11'(y); e.d[s] = 11'(d);
  endtask

  task automatic start_frame(input exp_t e);
    @(negedge clk_in);
    vsync_in = 1'b1;
    e.cyc = cyc + 23;
    exp_q.push_back(e);
    @(negedge clk_in);
    vsync_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk_in);
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(track_valid_out), 64'd0);
    chk({tag, "_x"}, 64'(track_x_out), 64'd0);
    chk({tag, "_y"}, 64'(track_y_out), 64'd0);
    chk({tag, "_d"}, 64'(track_d_out), 64'd0);
    chk({tag, "_fv"}, {63'd0, frame_valid_out}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_out}, 64'd0);
  endtask

  initial begin
    exp_t e;
    rst_in = 1'b0;
    vsync_in = 1'b0;
    clear_cands();
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Frame 1: two fresh candidates allocated to slots 0 and 1.
    clear_cands();
    set_cand(0, 100, 50, 20);
    set_cand(1, 300, 60, 18);
    e = blank(); e.valid = 4'b0011;
    set_slot(e, 0, 100, 50, 20);
    set_slot(e, 1, 300, 60, 18);
    start_frame(e);
    wait_drain();

    // Frame 2: candidate order swapped; slots keep identity.
    clear_cands();
    set_cand(0, 305, 62, 18);
    set_cand(1, 102, 49, 20);
    e = blank(); e.valid = 4'b0011;
`ifdef TRACKER_SMOOTH_EN
    set_slot(e, 0, 101, 50, 20);
    set_slot(e, 1, 303, 61, 18);
`else
    set_slot(e, 0, 102, 49, 20);
    set_slot(e, 1, 305, 62, 18);
`endif
    start_frame(e);
    wait_drain();

    // Frame 3: candidate too far from either track becomes a new slot 2.
    clear_cands();
    set_cand(0, 200, 50, 22);
    e.valid = 4'b0111;
    set_slot(e, 2, 200, 50, 22);
    start_frame(e);
    wait_drain();

    // Frames 4-6: no candidates; slots 0/1 die on the second, slot 2 on the third.
    clear_cands();
    e.valid = 4'b0111;
    start_frame(e);
    wait_drain();
    e.valid = 4'b0100;
    start_frame(e);
    wait_drain();
    e.valid = 4'b0000;
    start_frame(e);
    wait_drain();

    // Frame 7: second vsync mid-frame is dropped; later input changes are ignored.
    clear_cands();
    set_cand(0, 50, 40, 10);
    e = blank(); e.valid = 4'b0001;
    set_slot(e, 0, 50, 40, 10);
    start_frame(e);
    repeat (4) @(negedge clk_in);
    chk("busy_mid_frame", {63'd0, busy_out}, 64'd1);
    cand_x_in[0] = 11'd999;
    cand_valid_in = 4'hF;
    repeat (5) @(negedge clk_in);
    vsync_in = 1'b1;
    @(negedge clk_in);
    vsync_in = 1'b0;
    wait_drain();
    repeat (30) @(negedge clk_in);

    // Reset mid-frame: outputs clear at once and no frame completes.
    vsync_in = 1'b1;
    @(negedge clk_in);
    vsync_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (40) @(negedge clk_in);

    chk("frames_seen", 64'(frame_no), 64'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
